sync_ram_ctrl: RTL and testbench
================================

// Module: sync_ram_ctrl
// PURPOSE
//  Parametrised single-port synchronous RAM with request/valid handshake, byte-lane writes,
//  configurable read latency and post-reset clear sequencer. Next-generation data memory;
//  replaces the unclocked 16-bit-address / 32-bit-data memory.
//  Sits between the datapath load/store unit and on-chip storage; one access per cycle when Ready.
// PARAMETERS
//  DATA_WIDTH    32   data word width; must be a multiple of 8
//  ADDR_WIDTH    16   Address port width
//  DEPTH         256  words implemented; DEPTH <= 2**ADDR_WIDTH
//  READ_LATENCY  1    cycles from accepted read to Valid; legal values 1 or 2
// PORTS
//  clk        in   1             single clock, rising edge
//  reset      in   1             asynchronous, active-high
//  enable     in   1             access request
//  ReadWrite  in   1             1 = read, 0 = write
//  Address    in   ADDR_WIDTH    word address
//  DataIn     in   DATA_WIDTH    write data
//  ByteEn     in   DATA_WIDTH/8  write lane enables (bit i -> DataIn[8i+7:8i]); ignored on reads
//  DataOut    out  DATA_WIDTH    read data, qualified by Valid
//  Ready      out  1             block accepts a request this cycle
//  Valid      out  1             one-cycle pulse: DataOut holds read result
//  ParityErr  out  1             only with RAM_PARITY_EN; pulses with Valid on a parity mismatch
// BEHAVIOUR
//  - Reset (async assert, sync release): DataOut=0, Valid=0, Ready=0, ParityErr=0, read pipe flushed, FSM->CLEAR.
//  - FSM: CLEAR -> IDLE. CLEAR writes 0 to word ptr each cycle, ptr 0..DEPTH-1, Ready=0;
//    after writing DEPTH-1 -> IDLE, Ready=1 from the next cycle (DEPTH cycles after reset release).
//  - IDLE: request accepted at rising edge where enable && Ready. No stall; Ready stays 1 in IDLE.
//  - Write: lanes with ByteEn=1 updated at the accepting edge; other lanes retained. ByteEn=0 -> no-op.
//  - Read: mem[Address] sampled at the accepting edge; DataOut/Valid registered READ_LATENCY cycles
//    after acceptance (latency 1: visible the cycle after request). Back-to-back reads pipeline, 1/cycle.
//  - DataOut holds the last read value until the next Valid; Valid is low for writes.
//  - Write then read of the same address on the next cycle returns the new data.
//  - Address >= DEPTH: write dropped; read returns 0 with a normal Valid pulse (ParityErr=0).
//  - enable during CLEAR: ignored, no Valid generated; requester must wait for Ready.
//  - reset mid-read: in-flight reads discarded, no Valid; reset mid-CLEAR restarts CLEAR at word 0.
// CONFIGURATION
//  RAM_PARITY_EN defined: one even-parity bit per byte stored alongside data, computed on write and
//    on CLEAR (parity of 0 = 0); checked on read, ParityErr=1 in the Valid cycle if any lane mismatches.
//    Lanes not written keep their existing parity bit.
//  RAM_PARITY_EN undefined: no parity storage; ParityErr port absent.
// TESTING
//  1 reset, release, count cycles -> Ready=0 for exactly 256 cycles, then 1; read addr 0..3 -> all 0.
//  2 write 0xDEADBEEF @5 ByteEn=F, read @5 -> Valid 1 cycle later (LAT=1), DataOut=0xDEADBEEF.
//  3 write 0x11223344 @5 ByteEn=0101 over 0xDEADBEEF -> read 0xDE22BE44.
//  4 back-to-back reads @0..7 preloaded k*0x01010101, LAT=2 -> 8 consecutive Valid, data in order.
//  5 write @300, read @300 (DEPTH=256) -> DataOut=0, Valid=1; mem[300 mod 256] unchanged.
//  6 reset asserted with read in flight -> no Valid, DataOut=0; Ready low for 256 cycles after release.
//  7 RAM_PARITY_EN: force-flip one stored bit via hierarchy, read -> ParityErr=1 with Valid; clean read -> 0.

Source files
------------

// File: rtl/sync_ram_ctrl_if.sv
// Request/valid bus between a load/store unit (master) and sync_ram_ctrl (slave).
// RAM_PARITY_EN adds the ParityErr response signal.
interface sync_ram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                      enable;
    logic                      ReadWrite;
    logic [ADDR_WIDTH-1:0]     Address;
    logic [DATA_WIDTH-1:0]     DataIn;
    logic [DATA_WIDTH/8-1:0]   ByteEn;
    logic [DATA_WIDTH-1:0]     DataOut;
    logic                      Ready;
    logic                      Valid;
`ifdef RAM_PARITY_EN
    logic                      ParityErr;

    modport master (
        output enable, ReadWrite, Address, DataIn, ByteEn,
        input  DataOut, Ready, Valid, ParityErr
    );
    modport slave (
        input  enable, ReadWrite, Address, DataIn, ByteEn,
        output DataOut, Ready, Valid, ParityErr
    );
`else
    modport master (
        output enable, ReadWrite, Address, DataIn, ByteEn,
        input  DataOut, Ready, Valid
    );
    modport slave (
        input  enable, ReadWrite, Address, DataIn, ByteEn,
        output DataOut, Ready, Valid
    );
`endif
endinterface

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM with byte-lane writes, 1- or 2-cycle read latency and a
// post-reset clear sequencer. Define RAM_PARITY_EN for per-byte even parity with ParityErr.
module sync_ram_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    sync_ram_ctrl_if.slave    bus
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {CLEAR, IDLE} stateT;

    stateT                  state, nextState;
    logic [PTRW-1:0]        clearPtr;
    logic                   lastClear;
    logic                   ready;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   accept, readAccept, writeAccept, inRange;
    logic [PTRW-1:0]        wordIdx;
    logic [DATA_WIDTH-1:0]  rdData;
    logic                   pipeValid;
    logic [DATA_WIDTH-1:0]  pipeData;
    logic                   validQ;
    logic [DATA_WIDTH-1:0]  dataOutQ;

    assign lastClear   = (clearPtr == PTRW'(DEPTH - 1));
    assign accept      = bus.enable && ready;
    assign readAccept  = accept && bus.ReadWrite;
    assign writeAccept = accept && !bus.ReadWrite;
    assign inRange     = ({1'b0, bus.Address} < DEPTH_LIMIT);
    assign wordIdx     = bus.Address[PTRW-1:0];
    assign rdData      = inRange ? mem[wordIdx] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAR;
            clearPtr <= '0;
        end else begin
            state <= nextState;
            if (state == CLEAR)
                clearPtr <= lastClear ? '0 : clearPtr + 1'b1;
        end
    end

    always_comb begin
        nextState = state;
        ready     = 1'b0;
        case (state)
            CLEAR: if (lastClear) nextState = IDLE;
            IDLE:  ready = 1'b1;
            default: nextState = CLEAR;
        endcase
    end

`ifdef RAM_PARITY_EN
    logic [LANES-1:0] parMem [DEPTH];
    logic             rdErr;
    logic             pipeErr;
    logic             errQ;

    function automatic logic [LANES-1:0] lanePar(input logic [DATA_WIDTH-1:0] d);
        logic [LANES-1:0] p;
        p = '0;
        for (int i = 0; i < LANES; i++)
            p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    assign rdErr = inRange && (lanePar(mem[wordIdx]) != parMem[wordIdx]);
`endif

    // Storage has no reset: the CLEAR sequencer zeroes it word by word instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clearPtr] <= '0;
`ifdef RAM_PARITY_EN
            parMem[clearPtr] <= '0;
`endif
        end else if (writeAccept && inRange) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.ByteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= bus.DataIn[8*i +: 8];
`ifdef RAM_PARITY_EN
                    parMem[wordIdx][i] <= ^bus.DataIn[8*i +: 8];
`endif
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  stValid;
            logic [DATA_WIDTH-1:0] stData;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stValid <= 1'b0;
                    stData  <= '0;
                end else begin
                    stValid <= readAccept;
                    stData  <= rdData;
                end
            end
            assign pipeValid = stValid;
            assign pipeData  = stData;
`ifdef RAM_PARITY_EN
            logic stErr;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) stErr <= 1'b0;
                else       stErr <= rdErr;
            end
            assign pipeErr = stErr;
`endif
        end else begin : g_lat1
            assign pipeValid = readAccept;
            assign pipeData  = rdData;
`ifdef RAM_PARITY_EN
            assign pipeErr = rdErr;
`endif
        end
    endgenerate

    // DataOut only moves on a Valid so the last read result stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validQ   <= 1'b0;
            dataOutQ <= '0;
        end else begin
            validQ <= pipeValid;
            if (pipeValid)
                dataOutQ <= pipeData;
        end
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) errQ <= 1'b0;
        else       errQ <= pipeValid && pipeErr;
    end
    assign bus.ParityErr = errQ;
`endif

    assign bus.DataOut = dataOutQ;
    assign bus.Valid   = validQ;
    assign bus.Ready   = ready;
endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed bench for sync_ram_ctrl: dut1 uses READ_LATENCY=1, dut2 uses READ_LATENCY=2.
// Inputs change on falling edges, outputs are sampled on falling edges.
module tb_sync_ram_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   passed;
    int   cnt;
    int   validSeen;

    sync_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus1 ();
    sync_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus2 ();

    sync_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    sync_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rw;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        expValid;
        logic [31:0] expData;
    } vecT;

    vecT vecs [20];

    task automatic applyStimulus(input int sel, input logic en, input logic rw,
                                 input logic [15:0] addr, input logic [31:0] data,
                                 input logic [3:0] be);
        if (sel == 1) begin
            bus1.enable = en; bus1.ReadWrite = rw; bus1.Address = addr;
            bus1.DataIn = data; bus1.ByteEn = be;
        end else begin
            bus2.enable = en; bus2.ReadWrite = rw; bus2.Address = addr;
            bus2.DataIn = data; bus2.ByteEn = be;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Counts cycles until Ready rises on the chosen DUT, watching both for stray Valids.
    task automatic waitClear(input int sel, output int cycles, output int valids);
        cycles = 0;
        valids = 0;
        while (((sel == 1) ? bus1.Ready : bus2.Ready) !== 1'b1 && cycles < 1000) begin
            if (bus1.Valid === 1'b1 || bus2.Valid === 1'b1) valids++;
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        checks = 0;
        passed = 0;
        applyStimulus(1, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);
        applyStimulus(2, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);

        vecs[0]  = '{1'b1, 1'b1, 16'd0,   32'h0,        4'h0, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 16'd1,   32'h0,        4'h0, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 16'd2,   32'h0,        4'h0, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 16'd3,   32'h0,        4'h0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 16'd5,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 16'd5,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b0, 16'd5,   32'h11223344, 4'h5, 1'b0, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 1'b1, 16'd5,   32'h0,        4'h0, 1'b1, 32'hDE22BE44};
        vecs[8]  = '{1'b0, 1'b1, 16'd5,   32'h0,        4'h0, 1'b0, 32'hDE22BE44};
        vecs[9]  = '{1'b1, 1'b0, 16'd7,   32'hAABBCCDD, 4'h0, 1'b0, 32'hDE22BE44};
        vecs[10] = '{1'b1, 1'b1, 16'd7,   32'h0,        4'h0, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 16'd300, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 16'd300, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 16'd44,  32'h0,        4'h0, 1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 16'd44,  32'h12345678, 4'hA, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 16'd44,  32'h0,        4'h0, 1'b1, 32'h12005600};
        vecs[16] = '{1'b1, 1'b0, 16'd255, 32'h0F0F0F0F, 4'hF, 1'b0, 32'h12005600};
        vecs[17] = '{1'b1, 1'b1, 16'd255, 32'h0,        4'h0, 1'b1, 32'h0F0F0F0F};
        vecs[18] = '{1'b1, 1'b1, 16'd256, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[19] = '{1'b1, 1'b1, 16'd5,   32'h0,        4'h0, 1'b1, 32'hDE22BE44};

        repeat (3) @(negedge clk);
        checkOutput("reset Ready", 32'(bus1.Ready), 32'd0);
        checkOutput("reset Valid", 32'(bus1.Valid), 32'd0);
        checkOutput("reset DataOut", bus1.DataOut, 32'd0);

        // A request held during CLEAR must be ignored.
        applyStimulus(1, 1'b1, 1'b1, 16'd0, 32'd0, 4'h0);
        reset = 1'b0;
        waitClear(1, cnt, validSeen);
        applyStimulus(1, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);
        checkOutput("clear cycles", 32'(cnt), 32'd256);
        checkOutput("valid during clear", 32'(validSeen), 32'd0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].be);
            @(negedge clk);
            checkOutput($sformatf("vec%0d Valid", i), 32'(bus1.Valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d DataOut", i), bus1.DataOut, vecs[i].expData);
        end
        applyStimulus(1, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);
        @(negedge clk);
        checkOutput("idle Valid", 32'(bus1.Valid), 32'd0);

`ifdef RAM_PARITY_EN
        applyStimulus(1, 1'b1, 1'b1, 16'd5, 32'd0, 4'h0);
        @(negedge clk);
        checkOutput("clean ParityErr", 32'(bus1.ParityErr), 32'd0);
        u_dut1.mem[5][0] = ~u_dut1.mem[5][0];
        @(negedge clk);
        checkOutput("flip Valid", 32'(bus1.Valid), 32'd1);
        checkOutput("flip ParityErr", 32'(bus1.ParityErr), 32'd1);
        applyStimulus(1, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);
        @(negedge clk);
        checkOutput("ParityErr drops", 32'(bus1.ParityErr), 32'd0);
`endif

        // Latency-2 back-to-back reads of preloaded words.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2, 1'b1, 1'b0, 16'(k), 32'(k) * 32'h01010101, 4'hF);
            @(negedge clk);
        end
        applyStimulus(2, 1'b1, 1'b1, 16'd0, 32'd0, 4'h0);
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("lat2 Valid %0d", i), 32'(bus2.Valid),
                        (i >= 2 && i <= 9) ? 32'd1 : 32'd0);
            if (i >= 2 && i <= 9)
                checkOutput($sformatf("lat2 DataOut %0d", i), bus2.DataOut,
                            32'(i - 2) * 32'h01010101);
            if (i < 8) applyStimulus(2, 1'b1, 1'b1, 16'(i), 32'd0, 4'h0);
            else       applyStimulus(2, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);
        end

        // Reset while a latency-2 read is still in the pipe.
        applyStimulus(2, 1'b1, 1'b1, 16'd3, 32'd0, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(2, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);
        #1;
        checkOutput("midread Valid", 32'(bus2.Valid), 32'd0);
        checkOutput("midread DataOut", bus2.DataOut, 32'd0);
        @(negedge clk);
        checkOutput("midread late Valid", 32'(bus2.Valid), 32'd0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("midclear Ready", 32'(bus2.Ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        waitClear(2, cnt, validSeen);
        checkOutput("reclear cycles", 32'(cnt), 32'd256);
        checkOutput("reclear Valid", 32'(validSeen), 32'd0);

        applyStimulus(1, 1'b1, 1'b1, 16'd5, 32'd0, 4'h0);
        applyStimulus(2, 1'b1, 1'b1, 16'd3, 32'd0, 4'h0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);
        applyStimulus(2, 1'b0, 1'b1, 16'd0, 32'd0, 4'h0);
        checkOutput("cleared word Valid", 32'(bus1.Valid), 32'd1);
        checkOutput("cleared word DataOut", bus1.DataOut, 32'd0);
        checkOutput("lat2 early Valid", 32'(bus2.Valid), 32'd0);
        @(negedge clk);
        checkOutput("lat2 cleared Valid", 32'(bus2.Valid), 32'd1);
        checkOutput("lat2 cleared DataOut", bus2.DataOut, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
